// File: rtl/pipelined_csel_addsub_if.sv
// Operand/result handshake bundle for the pipelined carry-select adder/subtractor.
// The master side drives operands and the downstream ready; the slave side is the datapath.
interface pipelined_csel_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_csel_addsub.sv
// Pipelined carry-select adder/subtractor: BLK-bit dual-sum blocks, carry registered every BPS blocks,
// valid/ready handshake with per-stage bubble collapsing; flags computed alongside the final slice.
module pipelined_csel_addsub #(
    parameter int WIDTH = 32,
    parameter int BLK   = 4,
    parameter int BPS   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipelined_csel_addsub_if.slave bus
);
    localparam int SW   = BLK * BPS;
    localparam int NSTG = WIDTH / SW;

    // Stage inputs (combinational) and stage registers, indexed by stage.
    logic [WIDTH-1:0] a_in     [NSTG];
    logic [WIDTH-1:0] bx_in    [NSTG];
    logic [WIDTH-1:0] sum_in   [NSTG];
    logic [WIDTH-1:0] sum_next [NSTG];
    logic             c_in     [NSTG];
    logic             c_next   [NSTG];
    logic             v_in     [NSTG];

    logic [WIDTH-1:0] a_reg     [NSTG];
    logic [WIDTH-1:0] bx_reg    [NSTG];
    logic [WIDTH-1:0] sum_reg   [NSTG];
    logic             carry_reg [NSTG];
    logic             valid_reg [NSTG];
    logic             ovf_reg;
    logic             zero_reg;

    logic [NSTG:0]    load;
    logic             ovf_next;
    logic             zero_next;

    assign load[NSTG] = bus.out_ready;

    for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage
        logic [BPS:0]     chain;
        logic [SW-1:0]    slice;
        logic [WIDTH-1:0] merged;

        if (gi == 0) begin : g_first
            assign a_in[gi]   = bus.a;
            assign bx_in[gi]  = bus.sub ? ~bus.b : bus.b;
            assign c_in[gi]   = bus.sub | bus.cin;
            assign sum_in[gi] = '0;
            assign v_in[gi]   = bus.in_valid;
        end else begin : g_rest
            assign a_in[gi]   = a_reg[gi-1];
            assign bx_in[gi]  = bx_reg[gi-1];
            assign c_in[gi]   = carry_reg[gi-1];
            assign sum_in[gi] = sum_reg[gi-1];
            assign v_in[gi]   = valid_reg[gi-1];
        end

        // A stage may load when empty or when its own contents move on this edge.
        assign load[gi] = ~valid_reg[gi] | load[gi+1];

        assign chain[0] = c_in[gi];
        for (genvar gj = 0; gj < BPS; gj++) begin : g_blk
            localparam int LO = gi * SW + gj * BLK;
            logic [BLK:0] s0;
            logic [BLK:0] s1;
            assign s0 = {1'b0, a_in[gi][LO +: BLK]} + {1'b0, bx_in[gi][LO +: BLK]};
            assign s1 = {1'b0, a_in[gi][LO +: BLK]} + {1'b0, bx_in[gi][LO +: BLK]}
                        + {{BLK{1'b0}}, 1'b1};
            assign slice[gj*BLK +: BLK] = chain[gj] ? s1[BLK-1:0] : s0[BLK-1:0];
            assign chain[gj+1]          = chain[gj] ? s1[BLK]     : s0[BLK];
        end

        always_comb begin
            merged                = sum_in[gi];
            merged[gi*SW +: SW]   = slice;
        end

        assign sum_next[gi] = merged;
        assign c_next[gi]   = chain[BPS];
    end

    assign ovf_next  = (a_in[NSTG-1][WIDTH-1] == bx_in[NSTG-1][WIDTH-1]) &
                       (sum_next[NSTG-1][WIDTH-1] != a_in[NSTG-1][WIDTH-1]);
    assign zero_next = ~|sum_next[NSTG-1];

    // Data only moves with a valid beat, so bubbles never disturb held results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTG; k++) begin
                valid_reg[k] <= 1'b0;
                carry_reg[k] <= 1'b0;
                a_reg[k]     <= '0;
                bx_reg[k]    <= '0;
                sum_reg[k]   <= '0;
            end
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                if (load[k]) begin
                    valid_reg[k] <= v_in[k];
                    if (v_in[k]) begin
                        a_reg[k]     <= a_in[k];
                        bx_reg[k]    <= bx_in[k];
                        sum_reg[k]   <= sum_next[k];
                        carry_reg[k] <= c_next[k];
                    end
                end
            end
            if (load[NSTG-1] && v_in[NSTG-1]) begin
                ovf_reg  <= ovf_next;
                zero_reg <= zero_next;
            end
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = valid_reg[NSTG-1];
    assign bus.sum       = sum_reg[NSTG-1];
    assign bus.cout      = carry_reg[NSTG-1];
    assign bus.ovf       = ovf_reg;
    assign bus.zero      = zero_reg;
endmodule

// File: tb/tb_pipelined_csel_addsub.sv
// Directed bench for pipelined_csel_addsub: a hand-computed vector table plus stall,
// streaming and mid-flight reset sequences checked against a small arithmetic model.
module tb_pipelined_csel_addsub;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_csel_addsub_if #(.WIDTH(WIDTH)) bus ();

    pipelined_csel_addsub #(.WIDTH(WIDTH), .BLK(4), .BPS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
        logic        exp_zero;
    } vec_t;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int in_acc = 0;
    int out_cnt = 0;
    int first_in = -1;
    int first_out = -1;
    int last_out = -1;
    logic [34:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    // Reference: result = A + Bx + c0 with Bx/c0 chosen by SUB; flags as in the datasheet.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [31:0] bx;
        logic [32:0] r;
        logic        ov;
        bx = sub ? ~b : b;
        r  = {1'b0, a} + {1'b0, bx} + {32'd0, (sub | cin)};
        ov = (a[31] == bx[31]) && (r[31] != a[31]);
        return {r[32], ov, (r[31:0] == 32'd0), r[31:0]};
    endfunction

    // One clock: settle, record transfers for the scoreboard, advance to next falling edge.
    task automatic step();
        logic in_fire;
        logic out_fire;
        logic [34:0] e;
        #1;
        in_fire  = bus.in_valid & bus.in_ready;
        out_fire = bus.out_valid & bus.out_ready;
        if (out_fire) begin
            out_cnt++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_result", {29'd0, bus.cout, bus.ovf, bus.zero, bus.sum}, {29'd0, e});
            end
        end
        if (in_fire) begin
            in_acc++;
            if (first_in < 0) first_in = cyc;
            exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
    endtask

    task automatic drain(input int budget);
        int n;
        n = budget;
        while (exp_q.size() > 0 && n > 0) begin
            step();
            n--;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [12];
        int   lat;
        int   acc0;
        int   out0;
        logic [31:0] held;

        vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'h0000000F, 32'h00000001, 1'b1, 1'b0, 32'h00000011, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h12345678, 32'h0FEDCBA8, 1'b0, 1'b0, 32'h22222220, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{32'h000000FF, 32'hFFFFFF01, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{32'h00010000, 32'h00000001, 1'b0, 1'b1, 32'h0000FFFF, 1'b1, 1'b0, 1'b0};

        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {59'd0, bus.out_valid, bus.cout, bus.ovf, bus.zero, |bus.sum}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: nothing emerges, ready stays high.
        for (int i = 0; i < 10; i++) begin
            #1;
            check("idle_out_valid", {63'd0, bus.out_valid}, 64'd0);
            check("idle_sum", {32'd0, bus.sum}, 64'd0);
            check("idle_in_ready", {63'd0, bus.in_ready}, 64'd1);
            @(negedge clk);
        end

        // Single beats from the table, each timed from presentation to OUT_VALID.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            @(posedge clk);
            lat = 1;
            @(negedge clk);
            drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            while (!bus.out_valid && lat < 12) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            $display("vec %0d a=%h b=%h sub=%b cin=%b -> sum=%h c=%b v=%b z=%b lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
                     bus.sum, bus.cout, bus.ovf, bus.zero, lat);
            check("vec_latency", 64'(lat), 64'd4);
            check("vec_sum", {32'd0, bus.sum}, {32'd0, vecs[i].exp_sum});
            check("vec_flags", {61'd0, bus.cout, bus.ovf, bus.zero},
                  {61'd0, vecs[i].exp_cout, vecs[i].exp_ovf, vecs[i].exp_zero});
        end
        @(negedge clk);

        // Back-to-back stream with the sink always ready.
        exp_q.delete();
        first_in = -1; first_out = -1; last_out = -1; out0 = out_cnt;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drain(20);
        $display("stream first_in=%0d first_out=%0d last_out=%0d", first_in, first_out, last_out);
        check("stream_latency", 64'(first_out - first_in), 64'd4);
        check("stream_rate", 64'(last_out - first_out), 64'd15);
        check("stream_count", 64'(out_cnt - out0), 64'd16);

        // Sink stalled: exactly NSTG beats fit, then the result holds.
        bus.out_ready = 1'b0;
        acc0 = in_acc;
        out0 = out_cnt;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h01010101 * (i + 1), 32'h00110011 * i, 1'(i), 1'(i >> 1));
            step();
        end
        #1;
        check("stall_accepted", 64'(in_acc - acc0), 64'd4);
        check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("stall_out_valid", {63'd0, bus.out_valid}, 64'd1);
        held = bus.sum;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_held", {31'd0, bus.out_valid, bus.sum}, {31'd0, 1'b1, held});
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        drain(20);
        check("stall_released", 64'(out_cnt - out0), 64'd4);

        // Full pipe with ready sink: a new beat enters as the oldest leaves.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10000000 + i, 32'h0000FFFF, 1'b1, 1'b0);
            step();
        end
        bus.out_ready = 1'b1;
        drive(1'b1, 32'hDEADBEEF, 32'h12345678, 1'b0, 1'b1);
        #1;
        check("full_pass_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drain(20);

        // Reset with beats in flight: they vanish.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hA5A50000 + i, 32'h00000003, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        check("flight_out_valid", {63'd0, bus.out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("async_reset_sum", {32'd0, bus.sum}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        out0 = out_cnt;
        for (int i = 0; i < 10; i++) step();
        check("no_ghost_beats", 64'(out_cnt - out0), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
